// File: rtl/puzzle_regfile.sv
`default_nettype none
// ============================================================================
// Module   : puzzle_regfile
// Brief    : Sliding-puzzle register file. r0 holds the board, r1 the move
//            counter, r2 the origin snapshot; comp flags a solved board.
// Revision : 1.0
// ============================================================================
module puzzle_regfile #(
    parameter  int TILES  = 6,
    parameter  int TILE_W = 3,
    parameter  int DEPTH  = 16,
    parameter  int BYPASS = 1,
    localparam int W      = TILES * TILE_W,
    localparam int A      = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [A-1:0] dst,
    input  logic [W-1:0] data,
    input  logic [A-1:0] src0,
    input  logic [A-1:0] src1,
    input  logic         snap,
    input  logic         clr_cnt,
    output logic [W-1:0] data0,
    output logic [W-1:0] data1,
    output logic [W-1:0] cnt,
    output logic [W-1:0] org,
    output logic         comp
);

    // Solved board: tiles 1..TILES-1 from the MSB end, blank (0) in the last slot.
    function automatic logic [W-1:0] goal_pattern();
        logic [W-1:0] g;
        g = '0;
        for (int k = 0; k < TILES - 1; k++) begin
            g[W-1-k*TILE_W -: TILE_W] = TILE_W'(k + 1);
        end
        return g;
    endfunction

    localparam logic [W-1:0] c_GOAL    = goal_pattern();
    localparam logic [A-1:0] c_ADDR_R0 = A'(0);
    localparam logic [A-1:0] c_ADDR_R1 = A'(1);
    localparam logic [A-1:0] c_ADDR_R2 = A'(2);

    logic [W-1:0] r_regs [DEPTH];
    logic [W-1:0] w_next [DEPTH];
    logic         r_comp;
    logic         w_wr_board;
    logic         w_wr_cnt;
    logic         w_wr_org;

    assign w_wr_board = we && (dst == c_ADDR_R0);
    assign w_wr_cnt   = we && (dst == c_ADDR_R1);
    assign w_wr_org   = we && (dst == c_ADDR_R2);

    always_comb begin
        w_next = r_regs;
        if (we) begin
            w_next[dst] = data;
        end

        // Counter: explicit write beats clear, clear beats the move increment.
        if (w_wr_cnt) begin
            w_next[1] = data;
        end else if (clr_cnt) begin
            w_next[1] = '0;
        end else if (w_wr_board && !(&r_regs[1])) begin
            w_next[1] = r_regs[1] + W'(1);
        end else begin
            w_next[1] = r_regs[1];
        end

        // Snapshot takes the pre-edge board unless r2 is written directly.
        if (w_wr_org) begin
            w_next[2] = data;
        end else if (snap) begin
            w_next[2] = r_regs[0];
        end else begin
            w_next[2] = r_regs[2];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_regs[0] <= c_GOAL;
            r_comp    <= 1'b1;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= w_next[i];
            end
            r_comp <= (w_next[0] == c_GOAL);
        end
    end

    generate
        if (BYPASS != 0) begin : g_bypass
            // Forwarding is suppressed during reset so reads show reset contents.
            assign data0 = (!rst && we && (src0 == dst)) ? data : r_regs[src0];
            assign data1 = (!rst && we && (src1 == dst)) ? data : r_regs[src1];
        end else begin : g_no_bypass
            assign data0 = r_regs[src0];
            assign data1 = r_regs[src1];
        end
    endgenerate

    assign cnt  = r_regs[1];
    assign org  = r_regs[2];
    assign comp = r_comp;

endmodule
`default_nettype wire
